// File: rtl/arinc_tx_scheduler.sv
// ARINC-429 transmit scheduler: host FIFO, label reversal, inter-word gap, sticky IRQ flags.
// Define ARINC_TX_PARITY_GEN_EN to generate odd parity on bit 31 when txconfig[3]=1.
module arinc_tx_scheduler #(
    parameter  int DEPTH = 512,
    parameter  int GAPW  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     bufer_data,
    input  logic            bufer_wr,
    input  logic [7:0]      txconfig,
    output logic [1:0]      tx_speed,
    input  logic [GAPW-1:0] gap_cycles,
    input  logic [AW:0]     watermark,
    input  logic            fifo_flush,
    output logic            tx_valid,
    output logic [31:0]     tx_data,
    input  logic            tx_ready,
    output logic [AW:0]     fifo_level,
    input  logic [4:0]      txintmask,
    input  logic [4:0]      irq_clear,
    output logic [31:0]     txintflag,
    output logic            IRQ
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, GAP} state_e;

    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     rd_word_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    state_e          state_q;
    logic            tx_valid_q;
    logic [31:0]     tx_data_q, xform_word;
    logic [GAPW-1:0] gap_cnt_q;
    logic [1:0]      speed_q;
    logic            empty_q, sent_q, full_q, ovf_q, below_q;
    logic [15:0]     free_q;
    logic            full, wr_ok, rd_go, sent_evt, ovf_evt;

    assign full     = (level_q == DEPTH_L);
    assign wr_ok    = bufer_wr & ~full & ~fifo_flush;
    assign ovf_evt  = bufer_wr & full & ~fifo_flush;
    assign rd_go    = (state_q == IDLE) & txconfig[4] & (level_q != '0);
    assign sent_evt = (state_q == PRESENT) & tx_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_go) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_ok && !rd_go)      level_d = level_q + LVL_ONE;
            else if (rd_go && !wr_ok) level_d = level_q - LVL_ONE;
        end
    end

    // NOTE: the word storage has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= bufer_data;
        if (rd_go) rd_word_q <= mem_q[rd_ptr_q];
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        xform_word = rd_word_q;
        if (!txconfig[2]) begin
            for (int i = 0; i < 8; i++) xform_word[i] = rd_word_q[7-i];
        end
`ifdef ARINC_TX_PARITY_GEN_EN
        if (txconfig[3]) xform_word[31] = ~^xform_word[30:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (rd_go) state_q <= FETCH;
                FETCH: begin
                    tx_data_q  <= xform_word;
                    tx_valid_q <= 1'b1;
                    state_q    <= PRESENT;
                end
                PRESENT: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    gap_cnt_q  <= gap_cycles;
                    state_q    <= GAP;
                end
                // A loaded count of 0 or 1 both spend a single cycle here.
                GAP: begin
                    if (gap_cnt_q <= GAPW'(1)) state_q <= IDLE;
                    else                       gap_cnt_q <= gap_cnt_q - GAPW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_q <= '0;
            empty_q <= 1'b1;
            sent_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            below_q <= 1'b0;
            free_q  <= DEPTH_16;
        end else begin
            speed_q <= txconfig[1:0];
            empty_q <= (level_q == '0);
            full_q  <= full;
            below_q <= (level_q <= watermark);
            free_q  <= DEPTH_16 - 16'(level_q);
            // Set beats a same-cycle clear.
            sent_q  <= sent_evt | (sent_q & ~irq_clear[1]);
            ovf_q   <= ovf_evt  | (ovf_q  & ~irq_clear[3]);
        end
    end

`ifdef ARINC_TX_PARITY_GEN_EN
    logic unused_bits;
    assign unused_bits = ^{txconfig[7:5], irq_clear[4], irq_clear[2], irq_clear[0]};
`else
    logic unused_bits;
    assign unused_bits = ^{txconfig[7:5], txconfig[3], irq_clear[4], irq_clear[2], irq_clear[0]};
`endif

    assign tx_speed   = speed_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign fifo_level = level_q;
    assign txintflag  = {free_q, 11'b0, below_q, ovf_q, full_q, sent_q, empty_q};
    assign IRQ        = |({below_q, ovf_q, full_q, sent_q, empty_q} & txintmask);

endmodule

// File: tb/tb_arinc_tx_scheduler.sv
// Self-checking bench for arinc_tx_scheduler: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a queue-based behavioural model.
module tb_arinc_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int GAPW  = 16;
    localparam int AW    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     bufer_data = '0;
    logic            bufer_wr = 1'b0;
    logic [7:0]      txconfig = '0;
    logic [1:0]      tx_speed;
    logic [GAPW-1:0] gap_cycles = '0;
    logic [AW:0]     watermark = '0;
    logic            fifo_flush = 1'b0;
    logic            tx_valid;
    logic [31:0]     tx_data;
    logic            tx_ready = 1'b0;
    logic [AW:0]     fifo_level;
    logic [4:0]      txintmask = '0;
    logic [4:0]      irq_clear = '0;
    logic [31:0]     txintflag;
    logic            IRQ;

    arinc_tx_scheduler #(.DEPTH(DEPTH), .GAPW(GAPW)) dut (
        .clk(clk), .reset(rst_n), .bufer_data(bufer_data), .bufer_wr(bufer_wr),
        .txconfig(txconfig), .tx_speed(tx_speed), .gap_cycles(gap_cycles),
        .watermark(watermark), .fifo_flush(fifo_flush), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .fifo_level(fifo_level),
        .txintmask(txintmask), .irq_clear(irq_clear), .txintflag(txintflag), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] q[$];
    bit          m_held;
    logic [31:0] m_held_word;
    bit          m_pres_valid;
    logic [31:0] m_pres_data;
    int          n_edge, fetch_ok_at;
    logic [1:0]  m_speed;
    bit          m_empty, m_sent, m_full, m_ovf, m_below;
    logic [15:0] m_free;

    function automatic logic [31:0] model_xform(input logic [31:0] w, input logic [7:0] cfg);
        logic [31:0] r;
        logic [7:0]  lab;
        r = w;
        if (!cfg[2]) begin
            lab = w[7:0];
            r[7:0] = {<<{lab}};
        end
`ifdef ARINC_TX_PARITY_GEN_EN
        if (cfg[3]) r[31] = (($countones(r[30:0]) % 2) == 0);
`endif
        return r;
    endfunction

    function automatic logic [31:0] m_flags();
        return {m_free, 11'b0, m_below, m_ovf, m_full, m_sent, m_empty};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_held = 0; m_held_word = '0;
            m_pres_valid = 0; m_pres_data = '0;
            n_edge = 0; fetch_ok_at = 0;
            m_speed = '0;
            m_empty = 1; m_sent = 0; m_full = 0; m_ovf = 0; m_below = 0;
            m_free = 16'(DEPTH);
        end else begin : model_step
            int  lvl;
            bit  full_pre, hs, pop;
            n_edge++;
            lvl      = q.size();
            full_pre = (lvl == DEPTH);
            hs       = m_pres_valid && tx_ready;
            pop      = !m_held && !m_pres_valid && (n_edge >= fetch_ok_at) && txconfig[4] && (lvl != 0);

            m_speed = txconfig[1:0];
            m_empty = (lvl == 0);
            m_full  = full_pre;
            m_below = (lvl <= int'(watermark));
            m_free  = 16'(DEPTH - lvl);
            m_sent  = hs || (m_sent && !irq_clear[1]);
            m_ovf   = (bufer_wr && full_pre && !fifo_flush) || (m_ovf && !irq_clear[3]);

            // A word leaves the FIFO, is shown on the next edge, and the next fetch
            // is allowed no earlier than 1 + max(gap,1) edges after the accept.
            if (hs) begin
                m_pres_valid = 0;
                fetch_ok_at  = n_edge + 1 + ((gap_cycles == 0) ? 1 : int'(gap_cycles));
            end
            if (m_held) begin
                m_pres_data  = model_xform(m_held_word, txconfig);
                m_pres_valid = 1;
                m_held       = 0;
            end
            if (pop) begin
                m_held_word = q.pop_front();
                m_held      = 1;
            end
            if (fifo_flush) q.delete();
            else if (bufer_wr && !full_pre) q.push_back(bufer_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin : compare
            logic [31:0] mf;
            mf = m_flags();
            check("cmp_tx_valid", 32'(tx_valid), 32'(m_pres_valid));
            check("cmp_tx_data", tx_data, m_pres_data);
            check("cmp_tx_speed", 32'(tx_speed), 32'(m_speed));
            check("cmp_level", 32'(fifo_level), 32'(q.size()));
            check("cmp_flags", txintflag, mf);
            check("cmp_irq", 32'(IRQ), 32'(|(mf[4:0] & txintmask)));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [31:0] w);
        bufer_data = w;
        bufer_wr   = 1'b1;
        tick();
        bufer_wr   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) break;
        end
        check(name, 32'(tx_valid), 32'd1);
    endtask

    initial begin : main
        int rise[$];
        logic prev;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_speed", 32'(tx_speed), 32'd0);
        check("rst_flags", txintflag, 32'h0004_0001);
        check("rst_irq_masked", 32'(IRQ), 32'd0);
        txintmask = 5'b00001;
        #1;
        check("rst_irq_empty", 32'(IRQ), 32'd1);
        txintmask = '0;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // T1: label reversal and 2-edge latency
        txconfig = 8'h10;
        tx_ready = 1'b1;
        write_word(32'h0000_00A1);
        @(negedge clk);
        check("t1_valid_w0", 32'(tx_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_valid_w1", 32'(tx_valid), 32'd0);
        check("t1_empty_low", 32'(txintflag[0]), 32'd0);
        tick();
        @(negedge clk);
        check("t1_valid_w2", 32'(tx_valid), 32'd1);
        check("t1_data", tx_data, 32'h0000_0085);
        tick();
        @(negedge clk);
        check("t1_valid_drop", 32'(tx_valid), 32'd0);
        check("t1_sent", 32'(txintflag[1]), 32'd1);
        check("t1_empty_back", 32'(txintflag[0]), 32'd1);
        tick();
        irq_clear = 5'b00010;
        tick();
        irq_clear = '0;
        @(negedge clk);
        check("t1_sent_cleared", 32'(txintflag[1]), 32'd0);

        // T2: unreversed label with optional parity
        tick();
        txconfig = 8'h1C;
        write_word(32'h0000_0003);
        wait_valid("t2_valid_a");
`ifdef ARINC_TX_PARITY_GEN_EN
        check("t2_data_a", tx_data, 32'h8000_0003);
`else
        check("t2_data_a", tx_data, 32'h0000_0003);
`endif
        tick();
        write_word(32'h0000_0007);
        wait_valid("t2_valid_b");
        check("t2_data_b", tx_data, 32'h0000_0007);

        // T3: overflow with FIFO full
        tick();
        txconfig  = 8'h00;
        irq_clear = 5'h1F;
        tick();
        irq_clear = '0;
        for (int i = 0; i < 5; i++) write_word(32'h100 + i);
        @(negedge clk);
        check("t3_level", 32'(fifo_level), 32'd4);
        check("t3_full", 32'(txintflag[2]), 32'd1);
        check("t3_ovf", 32'(txintflag[3]), 32'd1);
        check("t3_free", 32'(txintflag[31:16]), 32'd0);
        tick();
        irq_clear = 5'b01000;
        tick();
        irq_clear = '0;
        @(negedge clk);
        check("t3_ovf_cleared", 32'(txintflag[3]), 32'd0);
        check("t3_full_kept", 32'(txintflag[2]), 32'd1);

        // T4: gap spacing
        tick();
        gap_cycles = 16'd10;
        txconfig   = 8'h10;
        tx_ready   = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (tx_valid && !prev) rise.push_back(c);
            prev = tx_valid;
        end
        check("t4_rises", 32'(rise.size()), 32'd4);
        for (int k = 1; k < rise.size(); k++) check("t4_spacing", 32'(rise[k] - rise[k-1]), 32'd13);

        // T5: flush while a word is presented
        tick();
        gap_cycles = '0;
        tx_ready   = 1'b0;
        write_word(32'h1234_5601);
        write_word(32'hAAAA_0002);
        write_word(32'h5555_0003);
        write_word(32'h0F0F_0004);
        @(negedge clk);
        check("t5_level_before", 32'(fifo_level), 32'd3);
        tick();
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        @(negedge clk);
        check("t5_valid_kept", 32'(tx_valid), 32'd1);
        check("t5_data_kept", tx_data, 32'h1234_5680);
        check("t5_level_flushed", 32'(fifo_level), 32'd0);
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        check("t5_accept", 32'(tx_valid), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("t5_idle", 32'(tx_valid), 32'd0);

        // T6: watermark IRQ, then reset mid-presentation
        tick();
        txconfig  = 8'h00;
        watermark = 3'd2;
        txintmask = 5'b10000;
        tick();
        write_word(32'h0000_0011);
        write_word(32'h0000_0022);
        write_word(32'h0000_0033);
        tick();
        @(negedge clk);
        check("t6_irq_low", 32'(IRQ), 32'd0);
        check("t6_level3", 32'(fifo_level), 32'd3);
        tick();
        txconfig = 8'h10;
        tick();
        @(negedge clk);
        check("t6_level2", 32'(fifo_level), 32'd2);
        check("t6_irq_lag", 32'(IRQ), 32'd0);
        tick();
        @(negedge clk);
        check("t6_irq_rise", 32'(IRQ), 32'd1);
        check("t6_presented", 32'(tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_flags", txintflag, 32'h0004_0001);
        tick();
        tick();
        rst_n = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bufer_wr   = ($urandom_range(0, 99) < 55);
            bufer_data = $urandom;
            txconfig   = {3'($urandom), ($urandom_range(0, 9) != 0), 4'($urandom)};
            tx_ready   = ($urandom_range(0, 99) < 60);
            gap_cycles = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 12)) : 16'($urandom_range(0, 2));
            watermark  = 3'($urandom_range(0, 4));
            fifo_flush = ($urandom_range(0, 99) < 3);
            irq_clear  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
            txintmask  = 5'($urandom);
            rst_n      = (i != 1500);
            tick();
        end
        bufer_wr = 1'b0;
        rst_n    = 1'b1;
        tick();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
